// File: rtl/tdm_demux_12.sv
// Twelve-slot time-division demultiplexer: hunts for the slot-0 frame marker,
// assembles 12 serial slot bits and presents each complete frame in parallel.
module tdm_demux_12 (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        en,
  input  logic        sync,
  output logic [11:0] o,
  output logic        valid,
  output logic [3:0]  slot,
  output logic        locked,
  output logic        err,
  output logic [7:0]  frm_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_SLOT = 4'd11;

  state_t      state;
  logic [11:0] asm_buf;

  // NOTE: every register here is state, so all assignments are non-blocking;
  // the pulse outputs default low at the top of the block and are only
  // raised by the branch that owns the event.
  always_ff @(posedge clk) begin
    valid <= 1'b0;
    err   <= 1'b0;
    if (rst) begin
      state   <= HUNT;
      asm_buf <= '0;
      o       <= '0;
      slot    <= '0;
      locked  <= 1'b0;
      frm_cnt <= '0;
    end else if (en) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            asm_buf[0] <= din;
            slot       <= 4'd1;
            state      <= RUN;
            locked     <= 1'b1;
          end
        end

        RUN: begin
          if (sync) begin
            // A marker anywhere but slot 0 drops the partial frame and
            // realigns on this bit immediately.
            err        <= (slot != 4'd0);
            asm_buf[0] <= din;
            slot       <= 4'd1;
          end else if (slot == 4'd0 || slot > LAST_SLOT) begin
            err    <= 1'b1;
            slot   <= 4'd0;
            state  <= HUNT;
            locked <= 1'b0;
          end else if (slot == LAST_SLOT) begin
            o       <= {din, asm_buf[10:0]};
            valid   <= 1'b1;
            frm_cnt <= frm_cnt + 8'd1;
            slot    <= 4'd0;
          end else begin
            asm_buf[slot] <= din;
            slot          <= slot + 4'd1;
          end
        end

        default: begin
          state  <= HUNT;
          locked <= 1'b0;
          slot   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux_12.sv
// Self-checking bench for tdm_demux_12: table vectors, directed corner cases
// and randomized traffic against a queue-based frame model.
module tb_tdm_demux_12;

  logic        clk = 1'b0;
  logic        rst, din, en, sync;
  logic [11:0] o;
  logic        valid, locked, err;
  logic [3:0]  slot;
  logic [7:0]  frm_cnt;

  tdm_demux_12 dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
    .o(o), .valid(valid), .slot(slot), .locked(locked),
    .err(err), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: collected slot bits of the current frame live in a queue.
  bit          q[$];
  logic [11:0] m_o;
  logic        m_valid, m_err, m_locked;
  int          m_cnt;

  typedef struct {
    logic        en, sync, din;
    logic        exp_valid;
    logic [3:0]  exp_slot;
    logic [11:0] exp_o;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic s, input logic d);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_o = '0; m_cnt = 0; m_locked = 1'b0; q.delete();
    end else if (e) begin
      if (!m_locked) begin
        if (s) begin
          q.delete(); q.push_back(d); m_locked = 1'b1;
        end
      end else if (s) begin
        if (q.size() != 0) m_err = 1'b1;
        q.delete(); q.push_back(d);
      end else if (q.size() == 0) begin
        m_err = 1'b1; m_locked = 1'b0;
      end else begin
        q.push_back(d);
        if (q.size() == 12) begin
          for (int i = 0; i < 12; i++) m_o[i] = q[i];
          m_valid = 1'b1;
          m_cnt   = (m_cnt + 1) % 256;
          q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic d);
    rst = r; en = e; sync = s; din = d;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, e, s, d);
    check("o", 32'(o), 32'(m_o));
    check("valid", 32'(valid), 32'(m_valid));
    check("err", 32'(err), 32'(m_err));
    check("locked", 32'(locked), 32'(m_locked));
    check("slot", 32'(slot), 32'(q.size()));
    check("frm_cnt", 32'(frm_cnt), 32'(m_cnt));
    check("valid_err_excl", 32'(valid & err), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic send_frame(input logic [11:0] f, input int gap);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, (i == 0), f[i]);
      if (i < 11) idle(gap);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    int          prev_valid;
    int          n_valid;
    pat = 12'hA5C;
    for (int i = 0; i < 12; i++) begin
      tbl[i].en        = 1'b1;
      tbl[i].sync      = (i == 0);
      tbl[i].din       = pat[i];
      tbl[i].exp_valid = (i == 11);
      tbl[i].exp_slot  = 4'((i + 1) % 12);
      tbl[i].exp_o     = (i == 11) ? 12'hA5C : 12'h000;
      tbl[i].exp_cnt   = (i == 11) ? 8'd1 : 8'd0;
    end

    rst = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
    m_o = '0; m_cnt = 0; m_locked = 1'b0; m_valid = 1'b0; m_err = 1'b0;

    // Reset state and the basic continuous frame from the table.
    do_reset();
    check("reset_o", 32'(o), 32'h0);
    check("reset_slot", 32'(slot), 32'h0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, tbl[i].en, tbl[i].sync, tbl[i].din);
      check("tbl_valid", 32'(valid), 32'(tbl[i].exp_valid));
      check("tbl_slot", 32'(slot), 32'(tbl[i].exp_slot));
      check("tbl_o", 32'(o), 32'(tbl[i].exp_o));
      check("tbl_cnt", 32'(frm_cnt), 32'(tbl[i].exp_cnt));
      check("tbl_locked", 32'(locked), 32'd1);
      check("tbl_err", 32'(err), 32'd0);
    end
    idle(1);
    check("valid_single", 32'(valid), 32'd0);

    // Same frame with strobe gaps.
    do_reset();
    send_frame(12'hA5C, 2);
    check("gap_o", 32'(o), 32'hA5C);
    check("gap_valid", 32'(valid), 32'd1);

    // Early sync on the 6th strobe of a frame.
    do_reset();
    send_frame(12'hFFF, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, (i == 0), 1'b0);
    pat = 12'h123;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, (i == 0), pat[i]);
      if (i == 0) check("early_err", 32'(err), 32'd1);
      if (i < 11) check("early_hold_o", 32'(o), 32'hFFF);
    end
    check("early_new_o", 32'(o), 32'h123);
    check("early_cnt", 32'(frm_cnt), 32'd2);

    // Missing sync after a locked frame, then recovery.
    do_reset();
    send_frame(12'h5A5, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("miss_err", 32'(err), 32'd1);
    check("miss_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom));
    check("miss_hunt_slot", 32'(slot), 32'd0);
    send_frame(12'h800, 0);
    check("miss_recover_o", 32'(o), 32'h800);
    check("miss_recover_cnt", 32'(frm_cnt), 32'd2);

    // 256 back-to-back frames: counter wrap and 12-cycle valid spacing.
    do_reset();
    prev_valid = -1;
    n_valid    = 0;
    for (int f = 0; f < 256; f++) begin
      pat = 12'($urandom);
      for (int i = 0; i < 12; i++) begin
        step(1'b0, 1'b1, (i == 0), pat[i]);
        if (valid) begin
          n_valid++;
          if (prev_valid >= 0) check("valid_spacing", 32'(cyc - prev_valid), 32'd12);
          prev_valid = cyc;
        end
      end
    end
    check("wrap_valids", 32'(n_valid), 32'd256);
    check("wrap_cnt", 32'(frm_cnt), 32'd0);

    // Reset in the middle of a frame.
    do_reset();
    send_frame(12'h3C3, 0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, (i == 0), 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst_o", 32'(o), 32'h0);
    check("midrst_slot", 32'(slot), 32'h0);
    check("midrst_locked", 32'(locked), 32'h0);
    check("midrst_cnt", 32'(frm_cnt), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("midrst_ignored", 32'(locked), 32'h0);

    // Randomized traffic: mostly well-formed sync, occasional faults and gaps.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic e, s;
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) s = 1'($urandom);
      else s = (q.size() == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(1'b0, e, s, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
